// File: rtl/bcd_field_counter_if.sv
// Control and status bundle between a BCD field counter and its driver.
interface bcd_field_counter_if;
    logic       tick_in;
    logic       set_ena;
    logic       up;
    logic       down;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] BCD_out;
    logic       TC_out;
    logic       load_err;

    modport master (
        output tick_in, set_ena, up, down, load, load_val,
        input  BCD_out, TC_out, load_err
    );

    modport slave (
        input  tick_in, set_ena, up, down, load, load_val,
        output BCD_out, TC_out, load_err
    );
endinterface

// File: rtl/bcd_field_counter.sv
// Two-digit BCD field counter with wrap, parallel load, set buttons and a one-cycle TC cascade.
module bcd_field_counter #(
    parameter int unsigned MOD_MIN   = 0,
    parameter int unsigned MOD_MAX   = 59,
    parameter int unsigned RESET_VAL = MOD_MIN
) (
    input logic               clk,
    input logic               rst,
    bcd_field_counter_if.slave bus
);

    localparam logic [7:0] MinBcd   = 8'(((MOD_MIN / 10) << 4) | (MOD_MIN % 10));
    localparam logic [7:0] MaxBcd   = 8'(((MOD_MAX / 10) << 4) | (MOD_MAX % 10));
    localparam logic [7:0] ResetBcd = 8'(((RESET_VAL / 10) << 4) | (RESET_VAL % 10));

    logic [7:0] bcd_q, bcd_d;
    logic       tc_q, tc_d;
    logic       err_q, err_d;
    logic       up_q, down_q;

    logic [3:0] ones, tens;
    logic [7:0] inc_val, dec_val;
    logic       up_edge, down_edge;
    logic       load_ok;

    assign ones      = bcd_q[3:0];
    assign tens      = bcd_q[7:4];
    assign up_edge   = bus.up & ~up_q;
    assign down_edge = bus.down & ~down_q;

    always_comb begin
        inc_val = {tens, ones + 4'd1};
        if (bcd_q == MaxBcd) begin
            inc_val = MinBcd;
        end else if (ones == 4'd9) begin
            inc_val = {tens + 4'd1, 4'd0};
        end
    end

    always_comb begin
        dec_val = {tens, ones - 4'd1};
        if (bcd_q == MinBcd) begin
            dec_val = MaxBcd;
        end else if (ones == 4'd0) begin
            dec_val = {tens - 4'd1, 4'd9};
        end
    end

    // Valid BCD orders like binary, so range checks compare the packed digits directly.
    // The lower bound is written as x+1 > min to stay meaningful when MOD_MIN is zero.
    always_comb begin
        load_ok = (bus.load_val[7:4] <= 4'd9) && (bus.load_val[3:0] <= 4'd9) &&
                  (({1'b0, bus.load_val} + 9'd1) > {1'b0, MinBcd}) &&
                  (bus.load_val <= MaxBcd);
    end

    always_comb begin
        bcd_d = bcd_q;
        tc_d  = 1'b0;
        err_d = 1'b0;
        if (bus.load) begin
            if (load_ok) begin
                bcd_d = bus.load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.set_ena) begin
            if (up_edge && !down_edge) begin
                bcd_d = inc_val;
            end else if (down_edge && !up_edge) begin
                bcd_d = dec_val;
            end
        end else if (bus.tick_in) begin
            bcd_d = inc_val;
            tc_d  = (bcd_q == MaxBcd);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q  <= ResetBcd;
            tc_q   <= 1'b0;
            err_q  <= 1'b0;
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            tc_q   <= tc_d;
            err_q  <= err_d;
            up_q   <= bus.up;
            down_q <= bus.down;
        end
    end

    assign bus.BCD_out  = bcd_q;
    assign bus.TC_out   = tc_q;
    assign bus.load_err = err_q;

endmodule

// File: tb/tb_bcd_field_counter.sv
// Drives a 00-59 and a 01-12 counter from shared stimulus and checks both against a decimal model.
module tb_bcd_field_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       set_ena = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_field_counter_if bus_a ();
    bcd_field_counter_if bus_b ();

    assign bus_a.tick_in  = tick;
    assign bus_a.set_ena  = set_ena;
    assign bus_a.up       = up;
    assign bus_a.down     = down;
    assign bus_a.load     = load;
    assign bus_a.load_val = load_val;
    assign bus_b.tick_in  = tick;
    assign bus_b.set_ena  = set_ena;
    assign bus_b.up       = up;
    assign bus_b.down     = down;
    assign bus_b.load     = load;
    assign bus_b.load_val = load_val;

    bcd_field_counter dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    bcd_field_counter #(
        .MOD_MIN  (1),
        .MOD_MAX  (12),
        .RESET_VAL(12)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    function automatic int mn(input int k);
        return (k == 0) ? 0 : 1;
    endfunction

    function automatic int mx(input int k);
        return (k == 0) ? 59 : 12;
    endfunction

    function automatic int rv(input int k);
        return (k == 0) ? 0 : 12;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    // Reference model: field value kept as a plain decimal integer.
    int mval[2];
    bit mtc[2];
    bit merr[2];
    bit upp = 1'b0;
    bit dnp = 1'b0;
    bit chk_en = 1'b0;

    always @(posedge clk) begin : model
        int nv[2];
        bit ntc[2];
        bit nerr[2];
        bit ue, de;
        int lt, lo, ln;
        ue = up && !upp;
        de = down && !dnp;
        lt = int'(load_val[7:4]);
        lo = int'(load_val[3:0]);
        ln = lt * 10 + lo;
        for (int k = 0; k < 2; k++) begin
            nv[k]   = mval[k];
            ntc[k]  = 1'b0;
            nerr[k] = 1'b0;
            if (rst) begin
                nv[k] = rv(k);
            end else if (load) begin
                if (lt <= 9 && lo <= 9 && ln >= mn(k) && ln <= mx(k)) nv[k] = ln;
                else nerr[k] = 1'b1;
            end else if (set_ena) begin
                if (ue && !de) nv[k] = (mval[k] == mx(k)) ? mn(k) : mval[k] + 1;
                else if (de && !ue) nv[k] = (mval[k] == mn(k)) ? mx(k) : mval[k] - 1;
            end else if (tick) begin
                if (mval[k] == mx(k)) begin
                    nv[k]  = mn(k);
                    ntc[k] = 1'b1;
                end else begin
                    nv[k] = mval[k] + 1;
                end
            end
        end
        mval <= nv;
        mtc  <= ntc;
        merr <= nerr;
        upp  <= rst ? 1'b0 : up;
        dnp  <= rst ? 1'b0 : down;
        if (rst) chk_en <= 1'b1;
    end

    task automatic check_model(input string nm, input logic [7:0] b, input logic t, input logic e,
                               input int k);
        n_tests++;
        if ({b, t, e} !== {to_bcd(mval[k]), mtc[k], merr[k]}) begin
            n_fail++;
            $display("FAIL %s @%0t: got bcd=%h tc=%b err=%b, want bcd=%h tc=%b err=%b", nm, $time,
                     b, t, e, to_bcd(mval[k]), mtc[k], merr[k]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check_model("model_a", bus_a.BCD_out, bus_a.TC_out, bus_a.load_err, 0);
            check_model("model_b", bus_b.BCD_out, bus_b.TC_out, bus_b.load_err, 1);
        end
    end

    task automatic lit(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, want %h", nm, $time, got, want);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        lit("reset_a", bus_a.BCD_out, 8'h00);
        lit("reset_b", bus_b.BCD_out, 8'h12);
        lit("reset_tc", {7'd0, bus_a.TC_out}, 8'h00);

        for (int i = 1; i <= 60; i++) begin
            tick = 1'b1;
            cyc();
            if (i == 1) begin
                lit("tick1_a", bus_a.BCD_out, 8'h01);
                lit("tick1_b", bus_b.BCD_out, 8'h01);
                lit("tick1_tc_b", {7'd0, bus_b.TC_out}, 8'h01);
            end
            if (i == 12) lit("tick12_b", bus_b.BCD_out, 8'h12);
            if (i == 59) begin
                lit("tick59_a", bus_a.BCD_out, 8'h59);
                lit("tick59_tc_a", {7'd0, bus_a.TC_out}, 8'h00);
            end
            if (i == 60) begin
                lit("wrap_a", bus_a.BCD_out, 8'h00);
                lit("wrap_tc_a", {7'd0, bus_a.TC_out}, 8'h01);
            end
        end
        tick = 1'b0;
        cyc();

        set_ena = 1'b1;
        down = 1'b1;
        cyc();
        lit("set_down_a", bus_a.BCD_out, 8'h59);
        lit("set_down_tc", {7'd0, bus_a.TC_out}, 8'h00);
        down = 1'b0;
        up = 1'b1;
        repeat (10) cyc();
        lit("up_held_a", bus_a.BCD_out, 8'h00);
        up = 1'b0;
        cyc();
        up = 1'b1;
        down = 1'b1;
        cyc();
        lit("up_down_a", bus_a.BCD_out, 8'h00);
        up = 1'b0;
        down = 1'b0;
        set_ena = 1'b0;

        load = 1'b1;
        load_val = 8'h47;
        cyc();
        lit("load47_a", bus_a.BCD_out, 8'h47);
        load_val = 8'h5A;
        cyc();
        lit("load5a_a", bus_a.BCD_out, 8'h47);
        lit("load5a_err", {7'd0, bus_a.load_err}, 8'h01);
        load_val = 8'h60;
        cyc();
        lit("load60_err", {7'd0, bus_a.load_err}, 8'h01);
        load = 1'b0;
        cyc();
        lit("err_clear", {7'd0, bus_a.load_err}, 8'h00);

        set_ena = 1'b1;
        up = 1'b1;
        tick = 1'b1;
        rst = 1'b1;
        cyc();
        lit("rst_mid_a", bus_a.BCD_out, 8'h00);
        rst = 1'b0;
        tick = 1'b0;
        cyc();
        lit("post_rst_up_a", bus_a.BCD_out, 8'h01);
        up = 1'b0;
        set_ena = 1'b0;

        for (int i = 0; i < 4000; i++) begin
            rst  = ($urandom % 97) == 0;
            tick = ($urandom % 3) == 0;
            if (($urandom % 16) == 0) set_ena = ~set_ena;
            up   = ($urandom % 4) == 0;
            down = ($urandom % 4) == 0;
            load = ($urandom % 10) == 0;
            if ($urandom % 2) load_val = to_bcd(int'($urandom % 100));
            else load_val = 8'($urandom);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_field_counter.md
Name: bcd_field_counter

Overview:
Parametrised two-digit BCD field counter for the digital clock: one instance each for seconds, minutes (00-59), hours (00-23 or 01-12), and further calendar fields. This block supersedes chained ripple-clocked digit counters. Everything runs on one clock, and fields cascade through a one-cycle tick/TC pulse chain. It adds range parameters, synchronous reset, parallel load, edge-detected set buttons with wrap in both directions, and a load error flag.

Parameters:
MOD_MIN, 0, lowest field value (decimal); legal range 0..98.
MOD_MAX, 59, highest field value (decimal); MOD_MIN < MOD_MAX <= 99.
RESET_VAL, MOD_MIN, value loaded on reset; must satisfy MOD_MIN..MOD_MAX.

Ports:
clk  in  1  system clock; all state changes on rising edge.
rst  in  1  synchronous, active-high reset.
tick_in  in  1  count-enable pulse from the lower field (or 1 Hz strobe); one cycle wide.
set_ena  in  1  level; 1 = set mode (tick_in ignored, up/down active).
up  in  1  level button, already debounced; rising edge = +1 in set mode.
down  in  1  level button, already debounced; rising edge = -1 in set mode.
load  in  1  one-cycle parallel load strobe.
load_val  in  8  BCD value to load; [7:4] = tens, [3:0] = ones.
BCD_out  out  8  current value; [7:4] = tens, [3:0] = ones; registered.
TC_out  out  1  terminal-count pulse to the next field; registered.
load_err  out  1  one-cycle pulse when a load is rejected; registered.

Behaviour:
- Reset (rst=1 at edge):
  - BCD_out = BCD(RESET_VAL); TC_out = 0; load_err = 0.
  - up/down edge registers are cleared to 0, so a button held through reset produces an edge on the first cycle after reset.
- Priority per cycle: rst > load > set mode (set_ena=1) > run mode (set_ena=0).
- Load:
  - A value is valid when both digits are <= 9 and MOD_MIN <= value <= MOD_MAX.
  - Valid: BCD_out <= load_val next cycle.
  - Invalid: BCD_out unchanged and load_err = 1 for exactly one cycle.
  - TC_out = 0 in any cycle where load is high.
  - tick_in and up/down edges arriving in a load cycle are dropped; edge registers still update.
- Run mode (set_ena=0):
  - tick_in=1 and BCD_out < MOD_MAX: increment by 1 in BCD. Ones 9 -> 0 carries into tens.
  - tick_in=1 and BCD_out = MOD_MAX: BCD_out <= MOD_MIN and TC_out = 1 in the same cycle the wrapped value appears.
  - TC_out is otherwise 0 and is never high for two consecutive cycles unless tick_in is.
  - up/down are ignored in run mode, but their edge registers keep sampling.
- Set mode (set_ena=1):
  - tick_in is ignored (dropped, not queued).
  - Rising edge of up: +1, with MOD_MAX -> MOD_MIN.
  - Rising edge of down: -1, with MOD_MIN -> MOD_MAX. Ones 0 borrows from tens and becomes 9.
  - No TC_out is generated in set mode, so setting minutes never disturbs hours.
  - Rising edges on up and down in the same cycle: no change.
  - A held button gives exactly one step.
- Latency: one cycle from any qualifying input to the new BCD_out.
- Arithmetic: digit-wise BCD with no binary conversion. The tens digit never exceeds MOD_MAX/10, and BCD_out never holds a non-BCD or out-of-range value.
- Changing set_ena has no side effect; the counter resumes from its held value.

Test Plan:
- Reset, then 60 tick_in pulses with defaults -> BCD_out steps 0x00..0x59 then 0x00; TC_out high only in the cycle BCD_out becomes 0x00.
- MOD_MIN=1, MOD_MAX=12, RESET_VAL=12: one tick -> BCD_out=0x01 with TC_out=1; 11 more ticks -> 0x12, TC_out=0 throughout.
- Set mode at 0x00: one down edge -> 0x59, TC_out=0; up held high for 10 cycles -> exactly one step, to 0x00; up and down rising together -> unchanged.
- Defaults: load 0x47 -> 0x47 next cycle; load 0x5A or 0x60 -> value unchanged and load_err=1 for one cycle; load coincident with tick_in at 0x59 -> 0x47 (or held value if the load is invalid), TC_out=0.
- rst asserted mid-count at 0x37 with tick_in=1 and up high -> 0x00, TC_out=0; first cycle after reset with set_ena=1 and up still high -> 0x01.
- Set mode at 0x59 with tick_in=1 -> value unchanged and no TC_out; drop set_ena, then one tick -> 0x00 with TC_out=1.
